segment_reader: RTL and testbench
=================================

Name: segment_reader

Overview:
- Reads a multiplexed, active-low 7-segment display bus driven by external equipment, such as a deck counter panel.
- Recovers a per-digit byte code in the same code space our segment decoder consumes: 0x00-0x0F hex, 0x10 dash, 0x20 underscore.
- Filters scan glitches with a stability counter and publishes a complete frame atomically.
- Sits between the external display header and the control/UART logic, so that readings enter the datapath.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; width of digit_sel; data_out is 8*NUM_DIGITS bits.
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a digit is accepted (min 2, max 255).

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  high = capture active; low = stability counter held at 0, no captures, outputs hold.
seg_in  input  7  segment lines, active-low, bit0=a .. bit6=g (0 = lit); asynchronous to clock.
digit_sel  input  NUM_DIGITS  digit strobes, active-high, expected one-hot; asynchronous.
data_out  output  8*NUM_DIGITS  decoded frame; digit i at bits [8i+7:8i]; digit NUM_DIGITS-1 is MSB.
frame_valid  output  1  one-cycle pulse when data_out updates.
glyph_error  output  1  high if the last published frame contained an unrecognised pattern.
sel_error  output  1  one-cycle pulse when a stable non-one-hot, non-zero digit_sel is seen.

Behaviour:
- Reset (synchronous, wins over everything):
  - data_out = 0x30 in every digit.
  - frame_valid = 0, glyph_error = 0, sel_error = 0.
  - Synchroniser flops = all-ones seg / zero sel.
  - Counter = 0; shadow = 0x30; seen mask = 0; pending-error = 0.
- Synchroniser: {digit_sel, seg_in} passes through two flops (s1, s2). s2 is the sample.
- Stability counter (width 8, saturating at STABLE_CYCLES):
  - Cleared when s2 differs from the previous s2, or when enable = 0.
  - Otherwise increments.
- Capture event: counter transitions STABLE_CYCLES-1 -> STABLE_CYCLES. It fires once per stable interval; holding the same value longer does not re-fire.
- On a capture event:
  - digit_sel one-hot (index i): shadow[i] <= decode(seg); seen[i] <= 1. If the code is 0xFF, pending-error <= 1.
  - digit_sel zero: ignored (blanking interval).
  - digit_sel multi-hot: no write; sel_error = 1 for one cycle.
- Decode, active-low pattern g..a to code:
  - 1000000 = 00, 1111001 = 01, 0100100 = 02, 0110000 = 03, 0011001 = 04
  - 0010010 = 05, 0000010 = 06, 1111000 = 07, 0000000 = 08, 0010000 = 09
  - 0001000 = 0A, 0000011 = 0B, 0100111 = 0C, 0100001 = 0D, 0000110 = 0E, 0001110 = 0F
  - 0111111 = 10 (dash), 1110111 = 20 (underscore), 1111111 = 30 (blank)
  - Any other pattern = FF.
- Re-capture of an already-seen digit before frame completion overwrites its shadow entry; this is not an error.
- Frame publish: on the edge after the seen mask becomes all-ones:
  - data_out <= shadow; glyph_error <= pending-error.
  - frame_valid = 1 for exactly one cycle.
  - seen <= 0; pending-error <= 0.
  - A capture on that same edge is applied to the freshly cleared mask.
- Latency: a pin value stable from before edge k is captured at edge k+2+STABLE_CYCLES. The publish, when it completes the frame, happens at the next edge.
- enable falling mid-frame: seen and shadow are retained; capture resumes when enable returns.
- reset mid-frame: discards the partial frame.

Test Plan:
- Reset: assert reset 3 cycles -> data_out = 0x30303030, frame_valid = 0, glyph_error = 0, sel_error = 0.
- Clean scan: digits 3..0 show 1, 2, 3, 4 (seg 1111001, 0100100, 0110000, 0011001). Each strobe held 40 cycles, 5-cycle blank between -> one frame_valid pulse, data_out = 0x01020304, glyph_error = 0. The pulse arrives 1 edge after digit 0 capture; no second pulse until all 4 are re-seen.
- Glitch rejection: digit 0 shows 0x08 with a 5-cycle excursion to 0x01 (STABLE_CYCLES = 16) -> digit 0 publishes 0x08; no capture of 0x01.
- Unknown glyph: digit 2 seg = 1010101 -> data_out[23:16] = 0xFF, glyph_error = 1 with frame_valid. The next clean frame clears glyph_error to 0.
- Select fault: digit_sel = 0011 stable 20 cycles -> exactly one sel_error pulse; seen and shadow unchanged.
- Reset mid-frame: capture digits 0 and 1, pulse reset, then scan all four with dash/underscore/blank/0xA -> a single frame_valid with data_out = 0x10_20_30_0A. No stale digits.

Source files
------------

// File: rtl/segment_reader.sv
// segment_reader: samples a multiplexed active-low 7-segment bus, debounces
// each digit, decodes it and publishes whole frames atomically.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   enable         capture active when high; outputs hold when low
//   seg_in         segment lines g..a, active-low, asynchronous
//   digit_sel      digit strobes, active-high one-hot, asynchronous
//   data_out       decoded frame, digit i at [8i+7:8i]
//   frame_valid    one-cycle pulse when data_out updates
//   glyph_error    last published frame held an unknown pattern
//   sel_error      one-cycle pulse on a stable multi-hot digit_sel
module segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [8*NUM_DIGITS-1:0]   data_out,
    output logic                      frame_valid,
    output logic                      glyph_error,
    output logic                      sel_error
);

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [SW-1:0] SYNC_RST = {{NUM_DIGITS{1'b0}}, 7'h7F};
    localparam logic [8*NUM_DIGITS-1:0] BLANK = {NUM_DIGITS{8'h30}};
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [SW-1:0]           s1, s2, s3;
    logic [7:0]              cnt;
    logic [NUM_DIGITS-1:0]   seen, seen_next;
    logic [8*NUM_DIGITS-1:0] shadow;
    logic                    pend, pend_next;

    logic [NUM_DIGITS-1:0]   sel;
    logic [6:0]              seg;
    logic [7:0]              code;
    logic                    capture, onehot, write_en, frame_done;

    function automatic logic [7:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 8'h00;
            7'b1111001: decode = 8'h01;
            7'b0100100: decode = 8'h02;
            7'b0110000: decode = 8'h03;
            7'b0011001: decode = 8'h04;
            7'b0010010: decode = 8'h05;
            7'b0000010: decode = 8'h06;
            7'b1111000: decode = 8'h07;
            7'b0000000: decode = 8'h08;
            7'b0010000: decode = 8'h09;
            7'b0001000: decode = 8'h0A;
            7'b0000011: decode = 8'h0B;
            7'b0100111: decode = 8'h0C;
            7'b0100001: decode = 8'h0D;
            7'b0000110: decode = 8'h0E;
            7'b0001110: decode = 8'h0F;
            7'b0111111: decode = 8'h10;
            7'b1110111: decode = 8'h20;
            7'b1111111: decode = 8'h30;
            default:    decode = 8'hFF;
        endcase
    endfunction

    always_comb begin
        sel        = s2[SW-1:7];
        seg        = s2[6:0];
        code       = decode(seg);
        // Fires only on the S-1 -> S step; saturation stops re-firing.
        capture    = enable && (s2 == s3) && (cnt == CNT_ARM);
        onehot     = (sel != '0) && ((sel & (sel - ONE)) == '0);
        write_en   = capture && onehot;
        frame_done = &seen;
        // A publish clears the mask first so a same-edge capture
        // lands in the new frame.
        seen_next  = frame_done ? '0 : seen;
        pend_next  = frame_done ? 1'b0 : pend;
        if (write_en) begin
            seen_next = seen_next | sel;
            if (code == 8'hFF) pend_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= SYNC_RST;
            s2          <= SYNC_RST;
            s3          <= SYNC_RST;
            cnt         <= '0;
            seen        <= '0;
            shadow      <= BLANK;
            pend        <= 1'b0;
            data_out    <= BLANK;
            frame_valid <= 1'b0;
            glyph_error <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            s1 <= {digit_sel, seg_in};
            s2 <= s1;
            s3 <= s2;
            if (!enable || s2 != s3)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
            sel_error   <= capture && !onehot && (sel != '0);
            frame_valid <= frame_done;
            if (frame_done) begin
                data_out    <= shadow;
                glyph_error <= pend;
            end
            for (int i = 0; i < NUM_DIGITS; i++)
                if (write_en && sel[i])
                    shadow[8*i +: 8] <= code;
            seen <= seen_next;
            pend <= pend_next;
        end
    end

endmodule

// File: tb/tb_segment_reader.sv
// tb_segment_reader: directed scans of a 4-digit display bus with
// hand-computed frames, glitch, glyph, select-fault and reset cases.
module tb_segment_reader;

    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GU = 7'b1110111;
    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GX = 7'b1010101;

    logic        clock = 0;
    logic        reset = 1;
    logic        enable = 1;
    logic [6:0]  seg_in = GB;
    logic [3:0]  digit_sel = '0;
    logic [31:0] data_out;
    logic        frame_valid, glyph_error, sel_error;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;
    logic [31:0] last_data = '0;
    logic        last_ge = 1'b0;

    segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .seg_in(seg_in), .digit_sel(digit_sel),
        .data_out(data_out), .frame_valid(frame_valid),
        .glyph_error(glyph_error), .sel_error(sel_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) begin
                fv_cnt    <= fv_cnt + 1;
                last_data <= data_out;
                last_ge   <= glyph_error;
            end
            if (sel_error) se_cnt <= se_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic hold(input logic [3:0] s, input logic [6:0] g,
                        input int n);
        digit_sel = s;
        seg_in    = g;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic show(input logic [3:0] s, input logic [6:0] g);
        hold(s, g, 40);
        hold(4'b0000, GB, 5);
    endtask

    task automatic settle();
        repeat (10) @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_data", data_out, 32'h30303030);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_ge", {31'd0, glyph_error}, 32'd0);
        check("rst_se", {31'd0, sel_error}, 32'd0);
        @(posedge clock); #1;

        // clean frame 1,2,3,4
        show(4'b1000, G1);
        show(4'b0100, G2);
        show(4'b0010, G3);
        show(4'b0001, G4);
        settle();
        check("clean_fv", fv_cnt, 1);
        check("clean_data", last_data, 32'h01020304);
        check("clean_ge", {31'd0, last_ge}, 32'd0);
        check("clean_out", data_out, 32'h01020304);

        // partial rescan must not publish
        show(4'b1000, G1);
        show(4'b0100, G2);
        show(4'b0010, G3);
        settle();
        check("partial_fv", fv_cnt, 1);

        // glitch on digit 0 completes the frame with 08
        hold(4'b0001, G8, 10);
        hold(4'b0001, G1, 5);
        hold(4'b0001, G8, 30);
        hold(4'b0000, GB, 5);
        settle();
        check("glitch_fv", fv_cnt, 2);
        check("glitch_data", last_data, 32'h01020308);

        // unknown glyph on digit 2
        show(4'b1000, G1);
        show(4'b0100, GX);
        show(4'b0010, G3);
        show(4'b0001, G4);
        settle();
        check("glyph_fv", fv_cnt, 3);
        check("glyph_data", last_data, 32'h01FF0304);
        check("glyph_ge", {31'd0, last_ge}, 32'd1);
        check("glyph_ge_out", {31'd0, glyph_error}, 32'd1);

        // next clean frame clears the error
        show(4'b1000, G1);
        show(4'b0100, G2);
        show(4'b0010, G3);
        show(4'b0001, G4);
        settle();
        check("reclean_fv", fv_cnt, 4);
        check("reclean_data", last_data, 32'h01020304);
        check("reclean_ge", {31'd0, glyph_error}, 32'd0);

        // multi-hot select fault
        hold(4'b0011, G2, 20);
        hold(4'b0000, GB, 5);
        settle();
        check("sel_pulse", se_cnt, 1);
        check("sel_fv", fv_cnt, 4);
        check("sel_data", data_out, 32'h01020304);

        // reset mid-frame discards digits 0 and 1
        show(4'b0001, G9);
        show(4'b0010, G9);
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check("midrst_data", data_out, 32'h30303030);
        check("midrst_fv", fv_cnt, 4);
        @(posedge clock); #1;
        show(4'b1000, GD);
        show(4'b0100, GU);
        show(4'b0010, GB);
        show(4'b0001, GA);
        settle();
        check("final_fv", fv_cnt, 5);
        check("final_data", last_data, 32'h1020300A);
        check("final_ge", {31'd0, last_ge}, 32'd0);
        check("final_se", se_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
